seq_det_tdm_sched: RTL and testbench

Time-multiplexed scheduler that shares one Moore "1010" non-overlapping detector next-state datapath among N_CH serial bit streams. Each cycle a round-robin arbiter grants one requesting channel, consumes that channel's bit, and advances that channel's saved detector state in a per-channel state file. The block reports detections tagged with the channel index and keeps a running detection count. It sits between the serial front-end channels and the event-collection logic.

---
 rtl/seq_det_tdm_sched.sv | 105 ++++++++++
 tb/tb_seq_det_tdm_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_tdm_sched.sv
// Round-robin time-multiplexed "1010" non-overlapping detector shared across N_CH serial channels.
// Gnt is combinational from Req; Det/Det_Ch/Cnt are registered one cycle after the grant; ungranted bits wait.
module seq_det_tdm_sched #(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [N_CH-1:0] req_i,
   input  logic [N_CH-1:0] in_i,
   input  logic [N_CH-1:0] clr_i,
   output logic [N_CH-1:0] gnt_o,
   output logic            det_o,
   output logic [CH_W-1:0] det_ch_o,
   output logic [7:0]      cnt_o
);

   localparam logic [2:0] S0    = 3'd0;
   localparam logic [2:0] S1    = 3'd1;
   localparam logic [2:0] S10   = 3'd2;
   localparam logic [2:0] S101  = 3'd3;
   localparam logic [2:0] S1010 = 3'd4;

   logic [2:0]      st_q [N_CH];
   logic [2:0]      st_d [N_CH];
   logic [CH_W-1:0] ptr_q, ptr_d;
   logic            det_q, det_d;
   logic [CH_W-1:0] det_ch_q, det_ch_d;
   logic [7:0]      cnt_q, cnt_d;

   logic [N_CH-1:0] elig;
   logic            gnt_any;
   logic [CH_W-1:0] gnt_idx;
   logic [CH_W-1:0] idx;
   int              j;
   logic [2:0]      cur_st, nxt_st;

   // Scan offsets from the highest down so the smallest offset from ptr_q wins.
   always_comb begin
      elig    = req_i & ~clr_i;
      gnt_any = 1'b0;
      gnt_idx = '0;
      j       = 0;
      idx     = '0;
      for (int o = N_CH - 1; o >= 0; o--) begin
         j = int'(ptr_q) + o;
         if (j >= N_CH) j = j - N_CH;
         idx = CH_W'(j);
         if (elig[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N_CH; i++) st_q[i] <= S0;
         ptr_q    <= '0;
         det_q    <= 1'b0;
         det_ch_q <= '0;
         cnt_q    <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) st_q[i] <= st_d[i];
         ptr_q    <= ptr_d;
         det_q    <= det_d;
         det_ch_q <= det_ch_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      cur_st = st_q[gnt_idx];
      case (cur_st)
         S0:      nxt_st = in_i[gnt_idx] ? S1   : S0;
         S1:      nxt_st = in_i[gnt_idx] ? S1   : S10;
         S10:     nxt_st = in_i[gnt_idx] ? S101 : S0;
         S101:    nxt_st = in_i[gnt_idx] ? S1   : S1010;
         S1010:   nxt_st = in_i[gnt_idx] ? S1   : S0;
         default: nxt_st = S0;
      endcase

      st_d = st_q;
      for (int i = 0; i < N_CH; i++) begin
         if (clr_i[i]) st_d[i] = S0;
      end
      // A cleared channel is never eligible, so the grant write cannot collide with a clear.
      if (gnt_any) st_d[gnt_idx] = nxt_st;

      ptr_d = ptr_q;
      if (gnt_any) ptr_d = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);

      det_d    = gnt_any && (nxt_st == S1010);
      det_ch_d = det_d ? gnt_idx : det_ch_q;
      cnt_d    = (det_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
   end

   always_comb begin
      gnt_o    = gnt_any ? (N_CH'(1) << gnt_idx) : '0;
      det_o    = det_q;
      det_ch_o = det_ch_q;
      cnt_o    = cnt_q;
   end

endmodule

// File: tb/tb_seq_det_tdm_sched.sv
// Table-driven directed sequences plus randomized traffic against a bit-history reference model.
module tb_seq_det_tdm_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req, din, clr, gnt;
   logic       det;
   logic [1:0] det_ch;
   logic [7:0] cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_det_tdm_sched #(.N_CH(4), .CH_W(2)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req_i   (req),
      .in_i    (din),
      .clr_i   (clr),
      .gnt_o   (gnt),
      .det_o   (det),
      .det_ch_o(det_ch),
      .cnt_o   (cnt)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] din;
      logic [3:0] clr;
      logic [3:0] gnt;
      logic       det;
      logic [1:0] ch;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[$];

   // Reference model: per-channel bits consumed since the last detection/clear/reset.
   int         ptr_m;
   logic [3:0] hist_m [4];
   int         nb_m [4];
   logic       exp_det;
   int         exp_ch;
   int         exp_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic [3:0] r, input logic [3:0] i, input logic [3:0] c,
                               input logic [3:0] g, input logic d, input logic [1:0] ch,
                               input logic [7:0] cn);
      vec_t v;
      v.req = r; v.din = i; v.clr = c; v.gnt = g; v.det = d; v.ch = ch; v.cnt = cn;
      tbl.push_back(v);
   endfunction

   function automatic void model_reset();
      ptr_m   = 0;
      exp_det = 1'b0;
      exp_ch  = 0;
      exp_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         hist_m[i] = 4'b0;
         nb_m[i]   = 0;
      end
   endfunction

   function automatic int model_gnt(input logic [3:0] r, input logic [3:0] c);
      for (int o = 0; o < 4; o++) begin
         int k;
         k = (ptr_m + o) % 4;
         if (r[k] && !c[k]) return k;
      end
      return -1;
   endfunction

   function automatic void model_edge(input logic [3:0] r, input logic [3:0] i, input logic [3:0] c);
      int g;
      g = model_gnt(r, c);
      for (int k = 0; k < 4; k++) begin
         if (c[k]) begin
            hist_m[k] = 4'b0;
            nb_m[k]   = 0;
         end
      end
      exp_det = 1'b0;
      if (g >= 0) begin
         hist_m[g] = {hist_m[g][2:0], i[g]};
         nb_m[g]   = nb_m[g] + 1;
         if (nb_m[g] >= 4 && hist_m[g] == 4'b1010) begin
            exp_det   = 1'b1;
            exp_ch    = g;
            hist_m[g] = 4'b0;
            nb_m[g]   = 0;
            if (exp_cnt < 255) exp_cnt = exp_cnt + 1;
         end
         ptr_m = (g + 1) % 4;
      end
   endfunction

   // Called just after a rising edge; returns Gnt mid-cycle and registered outputs after the edge.
   task automatic cyc(input logic [3:0] r, input logic [3:0] i, input logic [3:0] c,
                      output logic [3:0] g, output logic d, output logic [1:0] ch,
                      output logic [7:0] cn);
      req = r; din = i; clr = c;
      #2;
      g = gnt;
      @(posedge clk);
      #1;
      d = det; ch = det_ch; cn = cnt;
   endtask

   task automatic do_reset();
      req = 4'b0; din = 4'b0; clr = 4'b0;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] g;
      logic       d;
      logic [1:0] ch;
      logic [7:0] cn;
      int         eg;

      // Fairness from reset: each channel gets 1,0,1,0 in round-robin order.
      for (int k = 0; k < 16; k++)
         add(4'hF, ((k / 4) % 2 == 0) ? 4'hF : 4'h0, 4'h0, 4'(1 << (k % 4)),
             k >= 12, 2'(k % 4), (k >= 12) ? 8'(k - 11) : 8'd0);
      // Single channel 0.
      add(4'h1, 4'h1, 4'h0, 4'h1, 0, 0, 8'd4);
      add(4'h1, 4'h0, 4'h0, 4'h1, 0, 0, 8'd4);
      add(4'h1, 4'h1, 4'h0, 4'h1, 0, 0, 8'd4);
      add(4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 8'd5);
      add(4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 8'd5);
      // Non-overlap on channel 2: 1010 10 then 10 completes only from S10.
      for (int k = 0; k < 8; k++)
         add(4'h4, (k % 2 == 0) ? 4'h4 : 4'h0, 4'h0, 4'h4, (k == 3) || (k == 7), 2'd2,
             (k < 3) ? 8'd5 : (k < 7) ? 8'd6 : 8'd7);
      // Clear channel 3 from S101.
      add(4'h8, 4'h8, 4'h0, 4'h8, 0, 0, 8'd7);
      add(4'h8, 4'h0, 4'h0, 4'h8, 0, 0, 8'd7);
      add(4'h8, 4'h8, 4'h0, 4'h8, 0, 0, 8'd7);
      add(4'h8, 4'h0, 4'h8, 4'h0, 0, 0, 8'd7);
      add(4'h8, 4'h0, 4'h0, 4'h8, 0, 0, 8'd7);
      add(4'h8, 4'h8, 4'h0, 4'h8, 0, 0, 8'd7);
      add(4'h8, 4'h0, 4'h0, 4'h8, 0, 0, 8'd7);
      add(4'h8, 4'h8, 4'h0, 4'h8, 0, 0, 8'd7);
      add(4'h8, 4'h0, 4'h0, 4'h8, 1, 3, 8'd8);
      // Interleaved ch0 (1,0,1,0) and ch1 (1,1,1,1), then prove ch1 sits in S1.
      add(4'h3, 4'h3, 4'h0, 4'h1, 0, 0, 8'd8);
      add(4'h3, 4'h2, 4'h0, 4'h2, 0, 0, 8'd8);
      add(4'h3, 4'h2, 4'h0, 4'h1, 0, 0, 8'd8);
      add(4'h3, 4'h3, 4'h0, 4'h2, 0, 0, 8'd8);
      add(4'h3, 4'h3, 4'h0, 4'h1, 0, 0, 8'd8);
      add(4'h3, 4'h2, 4'h0, 4'h2, 0, 0, 8'd8);
      add(4'h3, 4'h2, 4'h0, 4'h1, 1, 0, 8'd9);
      add(4'h3, 4'h2, 4'h0, 4'h2, 0, 0, 8'd9);
      add(4'h2, 4'h0, 4'h0, 4'h2, 0, 0, 8'd9);
      add(4'h2, 4'h2, 4'h0, 4'h2, 0, 0, 8'd9);
      add(4'h2, 4'h0, 4'h0, 4'h2, 1, 1, 8'd10);

      req = 4'b0101; din = 4'b0; clr = 4'b0;
      rst_n = 1'b0;
      #2;
      chk("rst_det", det, 0);
      chk("rst_det_ch", det_ch, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_gnt_follows_req", gnt, 4'b0001);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (tbl[k]) begin
         cyc(tbl[k].req, tbl[k].din, tbl[k].clr, g, d, ch, cn);
         chk($sformatf("tbl%0d_gnt", k), g, tbl[k].gnt);
         chk($sformatf("tbl%0d_det", k), d, tbl[k].det);
         if (tbl[k].det) chk($sformatf("tbl%0d_det_ch", k), ch, tbl[k].ch);
         chk($sformatf("tbl%0d_cnt", k), cn, tbl[k].cnt);
      end

      // Saturation: 260 more detections on channel 2.
      for (int k = 0; k < 260; k++) begin
         cyc(4'h4, 4'h4, 4'h0, g, d, ch, cn);
         cyc(4'h4, 4'h0, 4'h0, g, d, ch, cn);
         cyc(4'h4, 4'h4, 4'h0, g, d, ch, cn);
         cyc(4'h4, 4'h0, 4'h0, g, d, ch, cn);
         chk($sformatf("sat%0d_det", k), d, 1);
         chk($sformatf("sat%0d_cnt", k), cn, (10 + k + 1 > 255) ? 255 : 10 + k + 1);
      end
      chk("sat_final_cnt", cnt, 255);

      // Mid-cycle reset while a detection is showing and the pointer sits at 3.
      req = 4'b0; din = 4'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_det", det, 0);
      chk("midrst_cnt", cnt, 0);
      chk("midrst_det_ch", det_ch, 0);
      req = 4'b1010;
      #1;
      chk("midrst_gnt_ptr0", gnt, 4'b0010);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(4'b1100, 4'b0, 4'b0, g, d, ch, cn);
      chk("postrst_first_gnt", g, 4'b0100);
      chk("postrst_det", d, 0);

      // Randomized traffic against the reference model.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         logic [3:0] r, i, c;
         r = 4'($urandom);
         i = 4'($urandom);
         for (int b = 0; b < 4; b++) c[b] = ($urandom_range(0, 7) == 0);
         eg = model_gnt(r, c);
         cyc(r, i, c, g, d, ch, cn);
         chk($sformatf("rnd%0d_gnt", k), g, (eg >= 0) ? 4'(1 << eg) : 4'h0);
         model_edge(r, i, c);
         chk($sformatf("rnd%0d_det", k), d, exp_det);
         if (exp_det) chk($sformatf("rnd%0d_det_ch", k), ch, exp_ch);
         chk($sformatf("rnd%0d_cnt", k), cn, exp_cnt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
